// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder with valid/ready handshaking.
//
// The operands are cut into STAGES equal slices. Stage k adds slice k using
// GROUP-bit lookahead groups, with group carries rippling across the slice.
// Each stage registers its slice carry-out for the next stage. It also
// forwards the operand bits not yet consumed and the sum bits already
// produced, so every beat stays aligned as it moves down the pipe.
//
// Optional build macro:
//   CLA_SUB_EN - adds a 'sub' input sampled with a/b. When sub=1 the block
//                computes a - b - c0 as a + ~b + !c0, and cout reads as
//                "no borrow".
module pipelined_cla_adder #(
    parameter int WIDTH  = 64,
    parameter int GROUP  = 2,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c0,
`ifdef CLA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    // Guarded divisors keep an illegal configuration from dividing by zero
    // before the checks below report it.
    localparam int STAGES_G = (STAGES < 1) ? 1 : STAGES;
    localparam int GROUP_G  = (GROUP < 1) ? 1 : GROUP;
    localparam int SLICE    = WIDTH / STAGES_G;
    localparam int NGRP     = SLICE / GROUP_G;

    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("pipelined_cla_adder: STAGES must be in 1..4");
    end
    if (GROUP < 1 || (WIDTH % (STAGES_G * GROUP_G)) != 0) begin : g_bad_split
        $error("pipelined_cla_adder: WIDTH must be divisible by STAGES*GROUP");
    end

    // One slice of the adder. Inside each GROUP-bit group, every carry is
    // written in sum-of-products lookahead form over the group generate and
    // propagate terms. The group carry-out then feeds the next group.
    // Returns {carry_out, sum}.
    function automatic logic [SLICE:0] cla_slice(
        input logic [SLICE-1:0] x,
        input logic [SLICE-1:0] y,
        input logic             ci
    );
        logic [SLICE-1:0] p;
        logic [SLICE-1:0] g;
        logic [SLICE-1:0] sum;
        logic             cg;
        logic             c;
        logic             pall;
        int               base;
        // NOTE: blocking assignments are correct here because this is pure
        // combinational evaluation in order. Clocked state below uses <=
        // only, so each stage samples its predecessor's pre-edge value.
        p   = x ^ y;
        g   = x & y;
        cg  = ci;
        sum = '0;
        for (int grp = 0; grp < NGRP; grp++) begin
            base = grp * GROUP_G;
            // i == GROUP_G produces the group carry-out.
            for (int i = 0; i <= GROUP_G; i++) begin
                c    = 1'b0;
                pall = 1'b1;
                for (int j = i - 1; j >= 0; j--) begin
                    c    = c | (pall & g[base + j]);
                    pall = pall & p[base + j];
                end
                c = c | (pall & cg);
                if (i < GROUP_G) begin
                    sum[base + i] = p[base + i] ^ c;
                end else begin
                    cg = c;
                end
            end
        end
        return {cg, sum};
    endfunction

    // Effective B operand and carry-in. Subtraction is folded in here, so
    // every stage downstream only sees an adder.
    logic [WIDTH-1:0] b_eff;
    logic             c_in;

`ifdef CLA_SUB_EN
    // Subtraction inverts B and the carry-in: a + ~b + !c0 == a - b - c0.
    always_comb begin
        b_eff = sub ? ~b : b;
        c_in  = sub ? ~c0 : c0;
    end
`else
    assign b_eff = b;
    assign c_in  = c0;
`endif

    logic ready_q;
    logic v_first;
    logic v_last;
    logic adv;

    // All stages past the first move together. They hold whenever the
    // output beat is stalled.
    assign adv = !v_last || out_ready;

    // Stage 0 can refill while the rest of the pipe is stalled, as long as
    // stage 0 itself is empty.
    assign in_ready = ready_q && (!v_first || adv);

    // Keeps in_ready low during reset. It rises at the first edge after
    // reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    for (genvar k = 0; k < STAGES_G; k++) begin : g_st
        // LO: sum bits known after this stage.
        // REM: operand bits still to be added at this stage's input.
        localparam int LO  = (k + 1) * SLICE;
        localparam int REM = WIDTH - k * SLICE;

        logic [REM-1:0] op_a;
        logic [REM-1:0] op_b;
        logic           cin_k;
        logic           v_in;
        logic           en;
        logic [SLICE:0] res;
        logic [LO-1:0]  s_d;
        logic           v_q;
        logic [LO-1:0]  s_q;

        if (k == 0) begin : g_src
            assign op_a  = a;
            assign op_b  = b_eff;
            assign cin_k = c_in;
            assign v_in  = in_valid;
            assign en    = in_ready;
            assign s_d   = res[SLICE-1:0];
        end else begin : g_src
            assign op_a  = g_st[k-1].g_fwd.a_q;
            assign op_b  = g_st[k-1].g_fwd.b_q;
            assign cin_k = g_st[k-1].g_fwd.cy_q;
            assign v_in  = g_st[k-1].v_q;
            assign en    = adv;
            assign s_d   = {res[SLICE-1:0], g_st[k-1].s_q};
        end

        assign res = cla_slice(op_a[SLICE-1:0], op_b[SLICE-1:0], cin_k);

        // Stage valid bit and accumulated low sum bits. A bubble moves the
        // valid bit but leaves the data registers untouched.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                // NOTE: datapath registers are cleared as well as the valid
                // bits, so s and the flags read 0 during and after reset.
                v_q <= 1'b0;
                s_q <= '0;
            end else if (en) begin
                v_q <= v_in;
                if (v_in) begin
                    s_q <= s_d;
                end
            end
        end

        if (k < STAGES_G - 1) begin : g_fwd
            logic [REM-SLICE-1:0] a_q;
            logic [REM-SLICE-1:0] b_q;
            logic                 cy_q;

            // Skew registers: unconsumed upper operand bits plus the
            // carry-out of this slice, handed to the next stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q  <= '0;
                    b_q  <= '0;
                    cy_q <= 1'b0;
                end else if (en && v_in) begin
                    a_q  <= op_a[REM-1:SLICE];
                    b_q  <= op_b[REM-1:SLICE];
                    cy_q <= res[SLICE];
                end
            end
        end else begin : g_fin
            logic cout_q;
            logic ovf_q;
            logic zero_q;

            // Result flags. They are formed in the final stage, where the
            // top slice and the full sum are available.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cout_q <= 1'b0;
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (en && v_in) begin
                    cout_q <= res[SLICE];
                    ovf_q  <= (op_a[SLICE-1] == op_b[SLICE-1]) &&
                              (res[SLICE-1] != op_a[SLICE-1]);
                    zero_q <= (s_d == '0);
                end
            end
        end
    end

    assign v_first   = g_st[0].v_q;
    assign v_last    = g_st[STAGES_G-1].v_q;
    assign out_valid = v_last;
    assign s         = g_st[STAGES_G-1].s_q;
    assign cout      = g_st[STAGES_G-1].g_fin.cout_q;
    assign ovf       = g_st[STAGES_G-1].g_fin.ovf_q;
    assign zero      = g_st[STAGES_G-1].g_fin.zero_q;

endmodule
